// File: rtl/hdmi_row_sched_pkg.sv
// Shared constants, state encoding and coordinate type for the HDMI row scheduler.
package hdmi_row_sched_pkg;

  localparam int unsigned OUT_ROWS = 1080;
  localparam int unsigned SRC_ROWS = 480;
  localparam int unsigned FRAC_W   = 5;
  localparam int unsigned INT_W    = 10;
  localparam int unsigned COORD_W  = INT_W + FRAC_W;
  localparam int unsigned ROW_W    = 11;
  localparam int unsigned COE_W    = 11;
  localparam int unsigned ROI_W    = 16;
  localparam int unsigned CMP_W    = 17;
  localparam int unsigned PROD_W   = 22;
  localparam int unsigned PINT_W   = PROD_W - FRAC_W;

  localparam logic [ROW_W-1:0]  LAST_ROW = ROW_W'(OUT_ROWS - 1);
  localparam logic [INT_W-1:0]  SAT_INT  = INT_W'(SRC_ROWS - 1);
  localparam logic [PINT_W-1:0] SAT_PINT = PINT_W'(SRC_ROWS - 1);

  // One-hot scheduler states
  typedef enum logic [2:0] {
    ST_IDLE  = 3'b001,
    ST_RUN   = 3'b010,
    ST_FLUSH = 3'b100
  } sched_state_t;

  // Source-row coordinate {integer row, fractional phase}
  typedef struct packed {
    logic [INT_W-1:0]  int_part;
    logic [FRAC_W-1:0] frac;
  } coord_t;

  // Clamp a scaled product to the last source row; the last row has no
  // neighbour below, so its fractional phase is always zero.
  function automatic coord_t sat_coord(input logic [PROD_W-1:0] prod);
    coord_t c;
    if (prod[PROD_W-1:FRAC_W] > SAT_PINT) begin
      c.int_part = SAT_INT;
      c.frac     = '0;
    end else begin
      c.int_part = prod[FRAC_W+INT_W-1:FRAC_W];
      c.frac     = prod[FRAC_W-1:0];
      if (c.int_part == SAT_INT) begin
        c.frac = '0;
      end
    end
    return c;
  endfunction

endpackage

// File: rtl/hdmi_row_coord.sv
// Three-stage ROI compare / scale / saturate pipeline for one output row per clock.
module hdmi_row_coord
  import hdmi_row_sched_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                issue,
  input  logic [ROW_W-1:0]    row,
  input  logic [COE_W-1:0]    coe,
  input  logic [ROI_W-1:0]    bh,
  input  logic [ROI_W-1:0]    eh,
  output logic [COORD_W-1:0]  coord,
  output logic                coord_vld,
  output logic                coord_we_c,
  output logic                drained_c
);

  logic signed [CMP_W-1:0] row_s;
  logic signed [CMP_W-1:0] bh_s;
  logic signed [CMP_W-1:0] eh_s;
  logic                    in_roi_c;

  logic                    s0_vld;
  logic                    s0_in_roi;
  logic [ROW_W-1:0]        s0_diff;

  logic                    s1_vld;
  logic                    s1_in_roi;
  logic [PROD_W-1:0]       s1_prod;

  logic                    s2_vld;
  logic                    s2_in_roi;
  coord_t                  s2_coord;

  // Signed ROI window test on the issued row
  always_comb begin
    row_s    = $signed(CMP_W'(row));
    bh_s     = $signed({bh[ROI_W-1], bh});
    eh_s     = $signed({eh[ROI_W-1], eh});
    in_roi_c = (row_s >= bh_s) && (row_s <= eh_s);
  end

  // S0: capture ROI flag and offset into the ROI
  always_ff @(posedge clk) begin
    if (rst) begin
      s0_vld    <= 1'b0;
      s0_in_roi <= 1'b0;
      s0_diff   <= '0;
    end else if (en) begin
      s0_vld    <= issue;
      s0_in_roi <= issue & in_roi_c;
      s0_diff   <= ROW_W'(row_s - bh_s);
    end
  end

  // S1: scale offset by the rate coefficient
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld    <= 1'b0;
      s1_in_roi <= 1'b0;
      s1_prod   <= '0;
    end else if (en) begin
      s1_vld    <= s0_vld;
      s1_in_roi <= s0_in_roi;
      s1_prod   <= PROD_W'(s0_diff) * PROD_W'(coe);
    end
  end

  // S2: saturate to the source image, black rows carry a zero coordinate
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld    <= 1'b0;
      s2_in_roi <= 1'b0;
      s2_coord  <= '0;
    end else if (en) begin
      s2_vld    <= s1_vld;
      s2_in_roi <= s1_in_roi;
      s2_coord  <= s1_in_roi ? sat_coord(s1_prod) : coord_t'('0);
    end
  end

  assign coord      = s2_coord;
  assign coord_vld  = s2_in_roi;
  // Write strobe must drop in the same cycle the FIFO reports full
  assign coord_we_c = s2_vld & en;
  // Nothing left in flight once the current S2 entry (if any) is written
  assign drained_c  = ~s0_vld & ~s1_vld & (~s2_vld | en);

endmodule

// File: rtl/hdmi_row_sched.sv
// Per-frame row scheduler: issues 1080 rows into the coordinate pipeline and
// latches resize parameters once per frame.
module hdmi_row_sched
  import hdmi_row_sched_pkg::*;
(
  input  logic                clk,
  input  logic                frst,
  input  logic                i_frame_start,
  input  logic [COE_W-1:0]    i_rate_coe,
  input  logic [ROI_W-1:0]    i_roi_bh,
  input  logic [ROI_W-1:0]    i_roi_eh,
  output logic [COORD_W-1:0]  o_fix_h,
  output logic                o_fix_h_vld,
  output logic                o_fix_h_we,
  input  logic                i_fix_h_full,
  output logic                o_busy,
  output logic                o_frame_done,
  output logic                o_overrun
);

  sched_state_t       state;
  logic [ROW_W-1:0]   row_cnt;
  logic [COE_W-1:0]   coe_sh;
  logic [ROI_W-1:0]   bh_sh;
  logic [ROI_W-1:0]   eh_sh;
  logic               en;
  logic               issue;
  logic               drained;

  assign en    = ~i_fix_h_full;
  assign issue = (state == ST_RUN) & en;

  hdmi_row_coord u_coord (
    .clk        (clk),
    .rst        (frst),
    .en         (en),
    .issue      (issue),
    .row        (row_cnt),
    .coe        (coe_sh),
    .bh         (bh_sh),
    .eh         (eh_sh),
    .coord      (o_fix_h),
    .coord_vld  (o_fix_h_vld),
    .coord_we_c (o_fix_h_we),
    .drained_c  (drained)
  );

  // Frame FSM, row counter, parameter shadows and status pulses
  always_ff @(posedge clk) begin
    if (frst) begin
      state        <= ST_IDLE;
      row_cnt      <= '0;
      coe_sh       <= '0;
      bh_sh        <= '0;
      eh_sh        <= '0;
      o_frame_done <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      o_overrun    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_frame_start) begin
            coe_sh  <= i_rate_coe;
            bh_sh   <= i_roi_bh;
            eh_sh   <= i_roi_eh;
            row_cnt <= '0;
            state   <= ST_RUN;
          end
        end
        ST_RUN: begin
          o_overrun <= i_frame_start;
          if (en) begin
            if (row_cnt == LAST_ROW) begin
              row_cnt <= '0;
              state   <= ST_FLUSH;
            end else begin
              row_cnt <= row_cnt + ROW_W'(1);
            end
          end
        end
        ST_FLUSH: begin
          o_overrun <= i_frame_start;
          if (drained) begin
            o_frame_done <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_busy = (state != ST_IDLE);

endmodule
